// File: rtl/sde_test_pulse_gen_if.sv
// Config/sample bundle for the synthetic SDE pulse source.
// master drives configuration, slave is the generator.
interface sde_test_pulse_gen_if #(
  parameter int ADC_WIDTH    = 12,
  parameter int PERIOD_WIDTH = 24
);
  logic [31:0]             PULSE_CTRL;
  logic [ADC_WIDTH-1:0]    PULSE_BASE;
  logic [ADC_WIDTH-1:0]    PULSE_AMP;
  logic [PERIOD_WIDTH-1:0] PULSE_PERIOD;
  logic                    PULSE_FIRE;
  logic [ADC_WIDTH-1:0]    ADC0;
  logic [ADC_WIDTH-1:0]    ADC1;
  logic [ADC_WIDTH-1:0]    ADC2;
  logic [ADC_WIDTH-1:0]    ADC_SSD;
  logic                    BUSY;
  logic [31:0]             PULSE_COUNT;

  modport master (
    output PULSE_CTRL, PULSE_BASE, PULSE_AMP,
    output PULSE_PERIOD, PULSE_FIRE,
    input  ADC0, ADC1, ADC2, ADC_SSD,
    input  BUSY, PULSE_COUNT
  );

  modport slave (
    input  PULSE_CTRL, PULSE_BASE, PULSE_AMP,
    input  PULSE_PERIOD, PULSE_FIRE,
    output ADC0, ADC1, ADC2, ADC_SSD,
    output BUSY, PULSE_COUNT
  );
endinterface

// File: rtl/sde_test_pulse_gen.sv
// Synthetic PMT/SSD pulse source for the 120 MHz trigger path.
// Three WCD channels plus one SSD channel with programmable delay.
module sde_test_pulse_gen #(
  parameter int ADC_WIDTH    = 12,
  parameter int PERIOD_WIDTH = 24
) (
  input logic               CLK120,
  input logic               RESET,
  sde_test_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_TAIL
  } state_t;

  localparam logic [ADC_WIDTH-1:0] ADC_MAX = '1;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              d_q, d_d;
  logic [3:0]              en_q, en_d;
  logic [ADC_WIDTH-1:0]    base_q, base_d;
  logic [ADC_WIDTH-1:0]    hi_q, hi_d;
  logic [31:0]             count_q, count_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic [15:0]             sr_q, sr_d;
  logic [ADC_WIDTH-1:0]    adc0_q, adc0_d;
  logic [ADC_WIDTH-1:0]    adc1_q, adc1_d;
  logic [ADC_WIDTH-1:0]    adc2_q, adc2_d;
  logic [ADC_WIDTH-1:0]    ssd_q, ssd_d;

  logic [3:0]              en_field;
  logic                    mode;
  logic                    run;
  logic [3:0]              w_field;
  logic [3:0]              d_field;
  logic                    unused_ctrl;

  logic                    idle;
  logic                    busy;
  logic                    active;
  logic                    start;
  logic [ADC_WIDTH:0]      sum;
  logic [ADC_WIDTH-1:0]    sat;
  logic [5:0]              min_p;
  logic [PERIOD_WIDTH-1:0] min_p_ext;
  logic [PERIOD_WIDTH-1:0] peff;
  logic [3:0]              tap_idx;
  logic                    dly;
  logic [ADC_WIDTH-1:0]    base_sel;

  assign en_field    = bus.PULSE_CTRL[3:0];
  assign mode        = bus.PULSE_CTRL[4];
  assign run         = bus.PULSE_CTRL[5];
  assign w_field     = bus.PULSE_CTRL[11:8];
  assign d_field     = bus.PULSE_CTRL[15:12];
  assign unused_ctrl = ^{bus.PULSE_CTRL[31:16],
                         bus.PULSE_CTRL[7:6]};

  assign idle   = (state_q == S_IDLE);
  assign busy   = !idle;
  assign active = (state_q == S_PULSE);

  // Periodic mode ignores FIRE; single-shot needs an explicit FIRE.
  assign start = idle && run &&
                 (mode ? (per_q == '0) : bus.PULSE_FIRE);

  assign sum = {1'b0, bus.PULSE_BASE} + {1'b0, bus.PULSE_AMP};
  assign sat = sum[ADC_WIDTH] ? ADC_MAX : sum[ADC_WIDTH-1:0];

  // Spacing can never be shorter than one full pulse+tail+idle.
  assign min_p     = {2'b00, w_field} + {2'b00, d_field} + 6'd2;
  assign min_p_ext = {{(PERIOD_WIDTH-6){1'b0}}, min_p};
  assign peff      = (bus.PULSE_PERIOD < min_p_ext) ?
                     min_p_ext : bus.PULSE_PERIOD;

  assign tap_idx  = d_q - 4'd1;
  assign dly      = (d_q == 4'd0) ? active : sr_q[tap_idx];
  assign base_sel = busy ? base_q : bus.PULSE_BASE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    en_d    = en_q;
    base_d  = base_q;
    hi_d    = hi_q;
    count_d = count_q;
    per_d   = (per_q != '0) ? per_q - 1'b1 : per_q;
    sr_d    = {sr_q[14:0], active};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PULSE;
          cnt_d   = w_field;
          d_d     = d_field;
          en_d    = en_field;
          base_d  = bus.PULSE_BASE;
          hi_d    = sat;
          count_d = count_q + 32'd1;
          per_d   = peff - 1'b1;
          sr_d    = '0;
        end
      end
      S_PULSE: begin
        if (cnt_q == 4'd0) begin
          if (d_q != 4'd0) begin
            state_d = S_TAIL;
            cnt_d   = d_q - 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adc0_d = (en_q[0] && active) ? hi_q : base_sel;
    adc1_d = (en_q[1] && active) ? hi_q : base_sel;
    adc2_d = (en_q[2] && active) ? hi_q : base_sel;
    ssd_d  = (en_q[3] && dly)    ? hi_q : base_sel;
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      en_q    <= '0;
      base_q  <= '0;
      hi_q    <= '0;
      count_q <= '0;
      per_q   <= '0;
      sr_q    <= '0;
      adc0_q  <= '0;
      adc1_q  <= '0;
      adc2_q  <= '0;
      ssd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
      base_q  <= base_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      per_q   <= per_d;
      sr_q    <= sr_d;
      adc0_q  <= adc0_d;
      adc1_q  <= adc1_d;
      adc2_q  <= adc2_d;
      ssd_q   <= ssd_d;
    end
  end

  assign bus.ADC0        = adc0_q;
  assign bus.ADC1        = adc1_q;
  assign bus.ADC2        = adc2_q;
  assign bus.ADC_SSD     = ssd_q;
  assign bus.BUSY        = busy;
  assign bus.PULSE_COUNT = count_q;

endmodule

// File: tb/tb_sde_test_pulse_gen.sv
// Directed bench for sde_test_pulse_gen: table-driven single shots
// plus hand sequences for periodic, robustness and reset cases.
module tb_sde_test_pulse_gen;

  localparam int AW = 12;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sde_test_pulse_gen_if #(.ADC_WIDTH(AW), .PERIOD_WIDTH(PW)) bus ();

  sde_test_pulse_gen #(.ADC_WIDTH(AW), .PERIOD_WIDTH(PW)) dut (
    .CLK120(clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]    en;
    int            w;
    int            d;
    logic [AW-1:0] base;
    logic [AW-1:0] amp;
    logic [AW-1:0] exp_hi;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_count = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mk(logic [3:0] en, logic mode,
                                     logic run, int w, int d);
    logic [3:0] wm1;
    logic [3:0] dd;
    wm1 = 4'(w - 1);
    dd  = 4'(d);
    return {16'h0, dd, wm1, 2'b00, run, mode, en};
  endfunction

  function automatic logic [AW-1:0] chan(int i);
    case (i)
      0: return bus.ADC0;
      1: return bus.ADC1;
      2: return bus.ADC2;
      default: return bus.ADC_SSD;
    endcase
  endfunction

  task automatic run_shot(int idx, vec_t v);
    logic hi;
    logic [AW-1:0] e;
    bus.PULSE_CTRL = mk(v.en, 1'b0, 1'b1, v.w, v.d);
    bus.PULSE_BASE = v.base;
    bus.PULSE_AMP  = v.amp;
    step(); step(); step();
    bus.PULSE_FIRE = 1'b1;
    exp_count++;
    for (int k = 0; k <= v.w + v.d + 3; k++) begin
      if (k > 0) begin
        step();
        bus.PULSE_FIRE = 1'b0;
      end
      check($sformatf("v%0d k%0d busy", idx, k), 32'(bus.BUSY),
            32'((k >= 1) && (k <= v.w + v.d)));
      for (int i = 0; i < 4; i++) begin
        if (i < 3) hi = (k >= 2) && (k <= 1 + v.w);
        else       hi = (k >= 2 + v.d) && (k <= 1 + v.d + v.w);
        e = (v.en[i] && hi) ? v.exp_hi : v.base;
        check($sformatf("v%0d k%0d ch%0d", idx, k, i),
              32'(chan(i)), 32'(e));
      end
    end
    check($sformatf("v%0d count", idx), bus.PULSE_COUNT, exp_count);
  endtask

  task automatic periodic(string tag, int per, int len,
                          int exp_gap, int exp_n);
    int last;
    int n;
    logic prev;
    int r;
    bus.PULSE_PERIOD = PW'(per);
    bus.PULSE_CTRL   = mk(4'hF, 1'b1, 1'b1, 4, 2);
    bus.PULSE_FIRE   = 1'b1;
    r = cyc;
    prev = 1'b0;
    last = -1;
    n = 0;
    for (int i = 0; i < len; i++) begin
      step();
      if (bus.BUSY && !prev) begin
        if (n == 0)
          check({tag, " first"}, 32'(cyc), 32'(r + 1));
        else
          check({tag, " gap"}, 32'(cyc - last), 32'(exp_gap));
        last = cyc;
        n++;
      end
      prev = bus.BUSY;
    end
    bus.PULSE_CTRL = mk(4'hF, 1'b1, 1'b0, 4, 2);
    bus.PULSE_FIRE = 1'b0;
    exp_count += 32'(exp_n);
    for (int i = 0; i < 20; i++) step();
    check({tag, " starts"}, 32'(n), 32'(exp_n));
    check({tag, " count"}, bus.PULSE_COUNT, exp_count);
    check({tag, " idle"}, 32'(bus.BUSY), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'hF, 3, 0, 12'd100, 12'd400, 12'd500};
    vecs[1] = '{4'hF, 2, 5, 12'd50, 12'd1000, 12'd1050};
    vecs[2] = '{4'h5, 1, 0, 12'd4000, 12'd500, 12'd4095};
    vecs[3] = '{4'hA, 16, 15, 12'd0, 12'd4095, 12'd4095};
    vecs[4] = '{4'h8, 1, 15, 12'd7, 12'd1, 12'd8};

    rst = 1'b1;
    bus.PULSE_CTRL   = '0;
    bus.PULSE_BASE   = 12'd100;
    bus.PULSE_AMP    = '0;
    bus.PULSE_PERIOD = '0;
    bus.PULSE_FIRE   = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++)
      check($sformatf("reset ch%0d", i), 32'(chan(i)), 32'd0);
    check("reset busy", 32'(bus.BUSY), 32'd0);
    check("reset count", bus.PULSE_COUNT, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_shot(i, vecs[i]);

    // FIRE while busy must be dropped, not queued.
    bus.PULSE_CTRL = mk(4'hF, 1'b0, 1'b1, 4, 0);
    bus.PULSE_BASE = 12'd10;
    bus.PULSE_AMP  = 12'd100;
    step(); step();
    bus.PULSE_FIRE = 1'b1;
    exp_count++;
    step(); bus.PULSE_FIRE = 1'b0;
    step(); bus.PULSE_FIRE = 1'b1;
    bus.PULSE_AMP = 12'd999;
    step(); bus.PULSE_FIRE = 1'b0;
    check("amp hold k3", 32'(bus.ADC0), 32'd110);
    step(); step();
    check("amp hold k5", 32'(bus.ADC1), 32'd110);
    check("fire busy k5", 32'(bus.BUSY), 32'd0);
    step(); step(); step();
    check("fire busy k8", 32'(bus.BUSY), 32'd0);
    check("fire busy count", bus.PULSE_COUNT, exp_count);

    bus.PULSE_CTRL = mk(4'hF, 1'b0, 1'b0, 4, 0);
    bus.PULSE_FIRE = 1'b1;
    step(); bus.PULSE_FIRE = 1'b0;
    check("run0 busy", 32'(bus.BUSY), 32'd0);
    step();
    check("run0 count", bus.PULSE_COUNT, exp_count);

    // RUN dropped mid-pulse: pulse and tail still finish.
    bus.PULSE_CTRL = mk(4'hF, 1'b0, 1'b1, 4, 3);
    bus.PULSE_AMP  = 12'd100;
    step();
    bus.PULSE_FIRE = 1'b1;
    exp_count++;
    step(); bus.PULSE_FIRE = 1'b0;
    step(); bus.PULSE_CTRL = mk(4'hF, 1'b0, 1'b0, 4, 3);
    step(); step(); step();
    check("run drop ssd k5", 32'(bus.ADC_SSD), 32'd110);
    step(); step();
    check("run drop busy k7", 32'(bus.BUSY), 32'd1);
    step();
    check("run drop busy k8", 32'(bus.BUSY), 32'd0);
    check("run drop ssd k8", 32'(bus.ADC_SSD), 32'd110);
    step();
    check("run drop ssd k9", 32'(bus.ADC_SSD), 32'd10);
    check("run drop count", bus.PULSE_COUNT, exp_count);

    periodic("per100", 100, 1000, 100, 10);
    periodic("per3", 3, 50, 7, 8);
    periodic("per0", 0, 35, 7, 5);

    // Reset in the middle of a long pulse.
    bus.PULSE_CTRL = mk(4'hF, 1'b0, 1'b1, 16, 4);
    bus.PULSE_BASE = 12'd20;
    bus.PULSE_AMP  = 12'd30;
    step(); step();
    bus.PULSE_FIRE = 1'b1;
    step(); bus.PULSE_FIRE = 1'b0;
    step(); step(); step();
    check("pre reset hi", 32'(bus.ADC2), 32'd50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("mid reset ch%0d", i), 32'(chan(i)), 32'd0);
    check("mid reset busy", 32'(bus.BUSY), 32'd0);
    check("mid reset count", bus.PULSE_COUNT, 32'd0);
    step();
    check("post reset base", 32'(bus.ADC0), 32'd20);
    bus.PULSE_FIRE = 1'b1;
    step(); bus.PULSE_FIRE = 1'b0;
    check("restart busy", 32'(bus.BUSY), 32'd1);
    check("restart count", bus.PULSE_COUNT, 32'd1);
    step();
    check("restart hi", 32'(bus.ADC0), 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
